// File: rtl/sprite_update_queue_if.sv
// Bundles the sprite write port, vblank/overflow control, renderer lookup and
// queue status of sprite_update_queue; slave is the queue, master is its environment.
interface sprite_update_queue_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [4:0]    sprite_sel;
   logic [9:0]    sprite_x;
   logic [8:0]    sprite_y;
   logic          sprite_pos;
   logic          sprite_attr;
   logic          sprite_vis;
   logic          vblank;
   logic          ovf_clr;
   logic [4:0]    rd_sel;
   logic [9:0]    rd_x;
   logic [8:0]    rd_y;
   logic [3:0]    rd_attr;
   logic          rd_vis;
   logic          q_full;
   logic          q_empty;
   logic [CW-1:0] q_count;
   logic          overflow;

   modport slave (
      input  sprite_sel, sprite_x, sprite_y, sprite_pos, sprite_attr, sprite_vis,
      input  vblank, ovf_clr, rd_sel,
      output rd_x, rd_y, rd_attr, rd_vis, q_full, q_empty, q_count, overflow
   );

   modport master (
      output sprite_sel, sprite_x, sprite_y, sprite_pos, sprite_attr, sprite_vis,
      output vblank, ovf_clr, rd_sel,
      input  rd_x, rd_y, rd_attr, rd_vis, q_full, q_empty, q_count, overflow
   );
endinterface

// File: rtl/sprite_update_queue.sv
// Queues sprite register writes and commits them to the 32-entry sprite table only
// during vblank. Define SPRITE_Q_BYPASS_EN to write straight through when idle in vblank.
module sprite_update_queue #(
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   sprite_update_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 27;

   // Entry layout: {vis, attr, pos, sel[4:0], x[9:0], y[8:0]}
   logic [EW-1:0] r_q [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_empty;
   logic          r_ovf;

   logic [9:0]    r_tx    [32];
   logic [8:0]    r_ty    [32];
   logic [3:0]    r_tattr [32];
   logic          r_tvis  [32];

   logic          w_strobe;
   logic          w_deq;
   logic          w_bypass;
   logic          w_enq;
   logic          w_drop;
   logic [EW-1:0] w_new_entry;
   logic [EW-1:0] w_commit;
   logic          w_commit_en;
   logic [CW-1:0] w_count_nxt;
   logic [2:0]    w_c_mask;
   logic [4:0]    w_c_sel;
   logic [9:0]    w_c_x;
   logic [8:0]    w_c_y;

   always_comb begin
      w_strobe    = bus.sprite_pos | bus.sprite_attr | bus.sprite_vis;
      w_new_entry = {bus.sprite_vis, bus.sprite_attr, bus.sprite_pos,
                     bus.sprite_sel, bus.sprite_x, bus.sprite_y};
      w_deq       = bus.vblank && !r_empty;
`ifdef SPRITE_Q_BYPASS_EN
      w_bypass    = bus.vblank && r_empty && w_strobe;
`else
      w_bypass    = 1'b0;
`endif
      // A full queue still accepts when the head leaves on the same edge.
      w_enq       = w_strobe && !w_bypass && (!r_full || w_deq);
      w_drop      = w_strobe && !w_bypass && !w_enq;
      w_commit_en = w_deq || w_bypass;
      w_commit    = w_bypass ? w_new_entry : r_q[r_rd_ptr];
      w_c_mask    = w_commit[26:24];
      w_c_sel     = w_commit[23:19];
      w_c_x       = w_commit[18:9];
      w_c_y       = w_commit[8:0];
      case ({w_enq, w_deq})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_enq) r_q[r_wr_ptr] <= w_new_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_ovf    <= 1'b0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
         if (w_drop)           r_ovf <= 1'b1;
         else if (bus.ovf_clr) r_ovf <= 1'b0;
      end
   end

   // Only the fields named in the entry mask are written; the rest of the sprite is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_tx[i]    <= '0;
            r_ty[i]    <= '0;
            r_tattr[i] <= '0;
            r_tvis[i]  <= 1'b0;
         end
      end else if (w_commit_en) begin
         if (w_c_mask[0]) begin
            r_tx[w_c_sel] <= w_c_x;
            r_ty[w_c_sel] <= w_c_y;
         end
         if (w_c_mask[1]) r_tattr[w_c_sel] <= w_c_x[3:0];
         if (w_c_mask[2]) r_tvis[w_c_sel]  <= w_c_x[0];
      end
   end

   assign bus.rd_x     = r_tx[bus.rd_sel];
   assign bus.rd_y     = r_ty[bus.rd_sel];
   assign bus.rd_attr  = r_tattr[bus.rd_sel];
   assign bus.rd_vis   = r_tvis[bus.rd_sel];
   assign bus.q_full   = r_full;
   assign bus.q_empty  = r_empty;
   assign bus.q_count  = r_count;
   assign bus.overflow = r_ovf;
endmodule
